pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Top-level game sequencer for the ping-pong design. Gates the graphics engine through `gra_still`, converts its hit/miss strobes into per-player scores and a rally count, and steps through new-game, play, new-ball and game-over phases. It uses the once-per-frame refresh tick for its inter-point and game-over delays. It sits between the button inputs, the `graph` engine and the score/text overlay.

## Interface

**Parameters**
- `WIN_SCORE`, default 11: points needed to win; legal range 1..15.
- `DELAY_TICKS`, default 120: frame ticks held in NEWBALL and OVER; 2 s at 60 Hz; legal range 1..255.

**Ports**
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-low reset.
- `tick`, in, 1: one-cycle pulse per frame, the same refresh tick the graphics engine uses.
- `btn`, in, 4: paddle buttons; any nonzero value counts as "start".
- `l_hit`, `r_hit`, in, 1 each: paddle-hit strobes from the graphics engine.
- `l_mis`, `r_mis`, in, 1 each: miss strobes from the graphics engine; level-held while the ball is out.
- `gra_still`, out, 1: freezes and re-centres the ball.
- `l_score`, `r_score`, out, 4 each: binary scores.
- `rally`, out, 8: paddle hits in the current point; saturates at 255.
- `game_over`, out, 1: high in OVER.
- `winner`, out, 1: 0 = left player, 1 = right player; valid while `game_over` is high.
- `state`, out, 2: 00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.

## Operation

**Reset (`reset` = 0 at a `clk` edge):**
- state = NEWGAME, `gra_still` = 1
- scores = 0, `rally` = 0, `winner` = 0, `game_over` = 0
- timer = 0

**NEWGAME**
- `gra_still` = 1; scores held at 0.
- `btn != 0` → PLAY; `rally` cleared.

**PLAY**
- `gra_still` = 0.
- `l_hit | r_hit` → `rally` +1, saturating at 255.
- `l_mis` → `r_score` +1; `r_mis` → `l_score` +1.
- If both miss strobes are high in the same cycle, `l_mis` wins and only `r_score` increments.
- After a miss, the new score is tested against the win condition:
  - win → OVER; timer = `DELAY_TICKS`; `winner` = scorer.
  - otherwise → NEWBALL; timer = `DELAY_TICKS`.
- Only the first cycle of a held miss is counted, because the state leaves PLAY on that cycle.
- A hit and a miss in the same cycle: the miss takes effect and `rally` is not incremented.

**NEWBALL**
- `gra_still` = 1; miss and hit strobes ignored.
- Timer decrements on each `tick` while nonzero.
- Timer == 0 and `btn != 0` → PLAY; `rally` cleared.

**OVER**
- `gra_still` = 1; `game_over` = 1; scores frozen.
- Timer decrements on each `tick`.
- Timer == 0 → NEWGAME; scores cleared and `winner` cleared on the same edge.

**Arithmetic and widths**
- Scores are 4-bit and saturate at 15; they never wrap.
- Timer is 8-bit; it never underflows and holds at 0.
- Win condition without the macro: scorer's new score == `WIN_SCORE`.

## Timing

- All outputs are registered, or decoded purely from registered state; there are no combinational paths from inputs to outputs.
- Event latency: an input event sampled at edge N appears on all outputs after edge N.
  - A miss at edge N: score update and the `gra_still` rise are both visible after edge N.
- NEWBALL dwell: at least `DELAY_TICKS` ticks, plus the wait for a button.
- OVER dwell: exactly `DELAY_TICKS` ticks, plus one clock.
- A `tick` arriving on the same edge as the state is entered does not decrement the timer, since the load takes priority.
- Reset mid-operation, in any state, forces the reset values on the next edge.

## Configuration

- `PONG_WIN_BY_TWO_EN` defined: a win requires both
  - scorer's new score >= `WIN_SCORE`, and
  - new score − opponent's score >= 2.
  - Reaching 15 always wins regardless of lead; this is the saturation cap.
- Undefined: the win check is the plain equality test against `WIN_SCORE`, with no lead test.

## Test plan

- **Reset and start:** hold `reset` = 0 for 3 clocks, then release.
  - Expect state = 00, `gra_still` = 1, scores = 0.
  - Pulse `btn` = 4'b0001 → state = 01, `gra_still` = 0 after one edge.
- **Point scoring:** in PLAY, hold `r_mis` for 50 clocks.
  - Expect `l_score` = 1 exactly once and state = 10.
  - Pressing `btn` before 120 ticks has no effect.
  - At tick 120 with `btn` pressed, state = 01.
- **Rally:** in PLAY, pulse `l_hit`/`r_hit` 300 times.
  - Expect `rally` = 255 (saturated).
  - A miss then NEWBALL→PLAY → `rally` = 0.
- **Simultaneous miss:** assert `l_mis` and `r_mis` on the same cycle at 0–0.
  - Expect `r_score` = 1, `l_score` = 0.
- **Game over:** drive the left player to 11–0.
  - Expect state = 11, `game_over` = 1, `winner` = 0.
  - After 120 ticks, state = 00 and scores = 0.
- **Win by two (macro defined):** play to 10–10, then left scores → 11–10 and state = 10.
  - Left scores again → 12–10 and state = 11.
  - Macro undefined: 11–10 goes straight to OVER.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
//
// Game sequencer for the ping-pong design. It holds the graphics engine
// frozen (gra_still) outside of live play, turns hit/miss strobes into
// per-player scores and a rally count, and steps through the phases
// NEWGAME -> PLAY -> NEWBALL/OVER. It uses the per-frame refresh tick to
// time the pause between points and the game-over screen.
//
// Optional build macro: PONG_WIN_BY_TWO_EN
//   When defined, a win needs the target score and a lead of two.
//   Reaching 15 (the score cap) always wins.
//   When undefined, a win is the plain equality test against WIN_SCORE.
//
// Parameters
//   WIN_SCORE   : points needed to win (1..15)
//   DELAY_TICKS : frame ticks held in NEWBALL and OVER (1..255)
//
// Ports
//   clk                 : system clock
//   reset               : synchronous, active-low reset
//   tick                : one-cycle pulse per frame
//   btn[3:0]            : paddle buttons; any nonzero value means "start"
//   l_hit, r_hit        : paddle-hit strobes from the graphics engine
//   l_mis, r_mis        : miss strobes (level-held while the ball is out)
//   gra_still           : freeze and re-centre the ball
//   l_score, r_score    : 4-bit binary scores
//   rally[7:0]          : paddle hits in the current point, saturating
//   game_over           : high in OVER
//   winner              : 0 = left, 1 = right; valid while game_over is high
//   state[1:0]          : 00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER

module pong_game_ctrl #(
  parameter int WIN_SCORE   = 11,
  parameter int DELAY_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] btn,
  input  logic       l_hit,
  input  logic       r_hit,
  input  logic       l_mis,
  input  logic       r_mis,
  output logic       gra_still,
  output logic [3:0] l_score,
  output logic [3:0] r_score,
  output logic [7:0] rally,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] state
);

  localparam logic [1:0] ST_NEWGAME = 2'b00;
  localparam logic [1:0] ST_PLAY    = 2'b01;
  localparam logic [1:0] ST_NEWBALL = 2'b10;
  localparam logic [1:0] ST_OVER    = 2'b11;

  localparam logic [3:0] WIN_VAL   = WIN_SCORE[3:0];
  localparam logic [7:0] DELAY_VAL = DELAY_TICKS[7:0];

  // Index 0 is the left player, index 1 the right player.
  logic [1:0] state_reg, state_next;
  logic [7:0] timer_reg, timer_next;
  logic [7:0] rally_reg, rally_next;
  logic       winner_reg, winner_next;
  logic [3:0] score_reg  [2];
  logic [3:0] score_next [2];

  // Per-player saturating increment and win test on the would-be score.
  logic [3:0] score_inc [2];
  logic [1:0] win;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      assign score_inc[gi] = (score_reg[gi] == 4'd15) ? 4'd15
                                                      : score_reg[gi] + 4'd1;
`ifdef PONG_WIN_BY_TWO_EN
      // Lead is compared in 5 bits so opponent + 2 cannot wrap.
      assign win[gi] = (score_inc[gi] == 4'd15) ||
                       ((score_inc[gi] >= WIN_VAL) &&
                        ({1'b0, score_inc[gi]} >= ({1'b0, score_reg[1-gi]} + 5'd2)));
`else
      assign win[gi] = (score_inc[gi] == WIN_VAL);
`endif
    end
  endgenerate

  logic start;
  logic timer_zero;
  assign start      = (btn != 4'd0);
  assign timer_zero = (timer_reg == 8'd0);

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    rally_next    = rally_reg;
    winner_next   = winner_reg;
    score_next[0] = score_reg[0];
    score_next[1] = score_reg[1];

    case (state_reg)
      ST_NEWGAME: begin
        score_next[0] = 4'd0;
        score_next[1] = 4'd0;
        if (start) begin
          state_next = ST_PLAY;
          rally_next = 8'd0;
        end
      end

      ST_PLAY: begin
        // A miss outranks a hit; l_mis outranks r_mis. Leaving PLAY on the
        // first miss cycle is what makes a held miss count only once.
        if (l_mis || r_mis) begin
          timer_next = DELAY_VAL;
          if (l_mis) begin
            score_next[1] = score_inc[1];
            if (win[1]) begin
              state_next  = ST_OVER;
              winner_next = 1'b1;
            end else begin
              state_next = ST_NEWBALL;
            end
          end else begin
            score_next[0] = score_inc[0];
            if (win[0]) begin
              state_next  = ST_OVER;
              winner_next = 1'b0;
            end else begin
              state_next = ST_NEWBALL;
            end
          end
        end else if ((l_hit || r_hit) && (rally_reg != 8'd255)) begin
          rally_next = rally_reg + 8'd1;
        end
      end

      ST_NEWBALL: begin
        if (timer_zero) begin
          if (start) begin
            state_next = ST_PLAY;
            rally_next = 8'd0;
          end
        end else if (tick) begin
          timer_next = timer_reg - 8'd1;
        end
      end

      default: begin // ST_OVER
        if (timer_zero) begin
          state_next    = ST_NEWGAME;
          score_next[0] = 4'd0;
          score_next[1] = 4'd0;
          winner_next   = 1'b0;
        end else if (tick) begin
          timer_next = timer_reg - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_NEWGAME;
      timer_reg    <= 8'd0;
      rally_reg    <= 8'd0;
      winner_reg   <= 1'b0;
      score_reg[0] <= 4'd0;
      score_reg[1] <= 4'd0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      rally_reg    <= rally_next;
      winner_reg   <= winner_next;
      score_reg[0] <= score_next[0];
      score_reg[1] <= score_next[1];
    end
  end

  // Outputs decode only registered state.
  assign state     = state_reg;
  assign gra_still = (state_reg != ST_PLAY);
  assign game_over = (state_reg == ST_OVER);
  assign winner    = winner_reg;
  assign rally     = rally_reg;
  assign l_score   = score_reg[0];
  assign r_score   = score_reg[1];

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed testbench for pong_game_ctrl with default parameters
// (WIN_SCORE = 11, DELAY_TICKS = 120).

module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] btn = 4'd0;
  logic       l_hit = 1'b0;
  logic       r_hit = 1'b0;
  logic       l_mis = 1'b0;
  logic       r_mis = 1'b0;
  logic       gra_still;
  logic [3:0] l_score;
  logic [3:0] r_score;
  logic [7:0] rally;
  logic       game_over;
  logic       winner;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  pong_game_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .btn       (btn),
    .l_hit     (l_hit),
    .r_hit     (r_hit),
    .l_mis     (l_mis),
    .r_mis     (r_mis),
    .gra_still (gra_still),
    .l_score   (l_score),
    .r_score   (r_score),
    .rally     (rally),
    .game_over (game_over),
    .winner    (winner),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // From NEWBALL: let the full delay run out, then press start.
  task automatic resume();
    btn = 4'd0;
    repeat (120) do_tick();
    btn = 4'd1;
    step();
    btn = 4'd0;
  endtask

  // One-cycle miss in PLAY; left_scores = 1 means the right player missed.
  task automatic score(input bit left_scores);
    if (left_scores) r_mis = 1'b1;
    else             l_mis = 1'b1;
    step();
    r_mis = 1'b0;
    l_mis = 1'b0;
  endtask

  initial begin
    // ---- reset ----
    reset = 1'b0;
    repeat (3) step();
    chk("rst_state", state, 0);
    chk("rst_still", gra_still, 1);
    chk("rst_lscore", l_score, 0);
    chk("rst_rscore", r_score, 0);
    chk("rst_rally", rally, 0);
    chk("rst_over", game_over, 0);
    chk("rst_winner", winner, 0);
    reset = 1'b1;
    step();
    chk("idle_newgame", state, 0);

    // ---- start ----
    btn = 4'b0001;
    step();
    btn = 4'd0;
    chk("start_state", state, 1);
    chk("start_still", gra_still, 0);

    // ---- held miss, with a tick on the entry edge ----
    r_mis = 1'b1;
    tick  = 1'b1;
    step();
    tick  = 1'b0;
    chk("miss_lscore", l_score, 1);
    chk("miss_state", state, 2);
    chk("miss_still", gra_still, 1);
    repeat (49) step();
    r_mis = 1'b0;
    chk("held_miss_once", l_score, 1);
    btn = 4'd1;
    repeat (3) step();
    chk("early_btn", state, 2);
    repeat (119) do_tick();
    chk("tick119", state, 2);
    do_tick();
    chk("tick120", state, 2);
    step();
    btn = 4'd0;
    chk("newball_play", state, 1);

    // ---- rally saturation ----
    l_hit = 1'b1;
    step();
    chk("rally1", rally, 1);
    l_hit = 1'b0;
    r_hit = 1'b1;
    step();
    chk("rally2", rally, 2);
    l_hit = 1'b1;
    repeat (298) step();
    l_hit = 1'b0;
    r_hit = 1'b0;
    chk("rally_sat", rally, 255);
    l_hit = 1'b1;
    score(1'b1);
    l_hit = 1'b0;
    chk("sat_miss_lscore", l_score, 2);
    chk("sat_miss_rally", rally, 255);
    resume();
    chk("rally_clr", rally, 0);

    // ---- hit and miss together ----
    l_hit = 1'b1;
    score(1'b1);
    l_hit = 1'b0;
    chk("hitmiss_rally", rally, 0);
    chk("hitmiss_lscore", l_score, 3);
    resume();

    // ---- left wins 11-0 ----
    for (int i = 4; i <= 10; i++) begin
      score(1'b1);
      resume();
    end
    chk("l10_score", l_score, 10);
    chk("l10_state", state, 1);
    score(1'b1);
    chk("win_state", state, 3);
    chk("win_over", game_over, 1);
    chk("win_winner", winner, 0);
    chk("win_lscore", l_score, 11);
    repeat (119) do_tick();
    chk("over119", state, 3);
    do_tick();
    chk("over120", state, 3);
    step();
    chk("over_exit_state", state, 0);
    chk("over_exit_lscore", l_score, 0);
    chk("over_exit_over", game_over, 0);

    // ---- simultaneous miss ----
    btn = 4'd2;
    step();
    btn = 4'd0;
    l_mis = 1'b1;
    r_mis = 1'b1;
    step();
    l_mis = 1'b0;
    r_mis = 1'b0;
    chk("both_rscore", r_score, 1);
    chk("both_lscore", l_score, 0);
    resume();

    // ---- 10-10 then left scores ----
    for (int i = 0; i < 19; i++) begin
      score(i < 10 ? 1'b1 : 1'b0);
      resume();
    end
    chk("deuce_l", l_score, 10);
    chk("deuce_r", r_score, 10);
    score(1'b1);
    chk("adv_lscore", l_score, 11);
`ifdef PONG_WIN_BY_TWO_EN
    chk("adv_state", state, 2);
    resume();
    score(1'b1);
    chk("two_lscore", l_score, 12);
`endif
    chk("deuce_win_state", state, 3);
    chk("deuce_winner", winner, 0);
    repeat (120) do_tick();
    step();
    chk("deuce_exit", state, 0);

    // ---- right wins 0-11 ----
    btn = 4'd8;
    step();
    btn = 4'd0;
    for (int i = 0; i < 10; i++) begin
      score(1'b0);
      resume();
    end
    score(1'b0);
    chk("rwin_state", state, 3);
    chk("rwin_winner", winner, 1);
    chk("rwin_rscore", r_score, 11);

    // ---- reset in OVER ----
    reset = 1'b0;
    step();
    chk("midrst_state", state, 0);
    chk("midrst_winner", winner, 0);
    chk("midrst_rscore", r_score, 0);
    chk("midrst_over", game_over, 0);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
